// File: rtl/fxp_blend_clamp_pipe.sv
// Three-stage fixed-point blend: y = clamp(deadband(KV * (WT*t + WZ*z))) on a valid/ready stream.
// Define FXP_BLEND_ROUND_EN to round half toward +inf at both rescaling shifts instead of truncating.
module fxp_blend_clamp_pipe #(
    parameter int W       = 32,
    parameter int FRAC    = 16,
    parameter int WT_P    = 49152,
    parameter int WZ_P    = 16384,
    parameter int KV_P    = 32768,
    parameter int LIMIT_P = 131072,
    parameter int EPS_P   = 655,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_t,
    input  logic signed [W-1:0] in_z,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_y,
    output logic                out_sat,
    input  logic                clr_cnt,
    output logic [CNT_W-1:0]    sat_cnt
);

`ifdef FXP_BLEND_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    // Rounding adds a half-LSB offset before the shift, so every sum carries one spare bit.
    localparam int SW  = W + 1 + RND;
    localparam int MW  = W + 2 + RND;
    localparam int P1W = 2 * W + RND;
    localparam int P2W = SW + W + RND;

    localparam logic signed [P1W-1:0] WT_C  = P1W'(WT_P);
    localparam logic signed [P1W-1:0] WZ_C  = P1W'(WZ_P);
    localparam logic signed [P2W-1:0] KV_C  = P2W'(KV_P);
    localparam logic signed [P1W-1:0] HALF1 = P1W'(RND) << (FRAC - 1);
    localparam logic signed [P2W-1:0] HALF2 = P2W'(RND) << (FRAC - 1);
    localparam logic signed [MW-1:0]  LIM_M = MW'(LIMIT_P);
    localparam logic signed [MW-1:0]  EPS_M = MW'(EPS_P);
    localparam logic signed [W-1:0]   LIM_W = W'(LIMIT_P);
    localparam logic [CNT_W-1:0]      CNT_MAX = '1;

    // Handshake: a beat moves on valid && ready. The only stall source is a held
    // output (out_valid && !out_ready); then every stage freezes and in_ready drops.
    // Otherwise all stages advance together and empty slots travel as valid=0.
    logic w_stall;
    logic w_adv;

    logic                r_s1_valid;
    logic signed [SW-1:0] r_s1_s;
    logic                r_s2_valid;
    logic signed [MW-1:0] r_s2_m;
    logic                r_out_valid;
    logic signed [W-1:0] r_out_y;
    logic                r_out_sat;
    logic [CNT_W-1:0]    r_sat_cnt;

    assign w_stall = r_out_valid && !out_ready;
    assign w_adv   = !w_stall;

    // Stage 1: weighted sum of target and measurement.
    logic signed [P1W-1:0] w_t_ext;
    logic signed [P1W-1:0] w_z_ext;
    logic signed [P1W-1:0] w_pt_prod;
    logic signed [P1W-1:0] w_pz_prod;
    logic signed [SW-1:0]  w_pt;
    logic signed [SW-1:0]  w_pz;
    logic signed [SW-1:0]  w_s;

    assign w_t_ext   = P1W'(in_t);
    assign w_z_ext   = P1W'(in_z);
    assign w_pt_prod = w_t_ext * WT_C + HALF1;
    assign w_pz_prod = w_z_ext * WZ_C + HALF1;
    assign w_pt      = SW'(w_pt_prod >>> FRAC);
    assign w_pz      = SW'(w_pz_prod >>> FRAC);
    assign w_s       = w_pt + w_pz;

    // Stage 2: output gain, kept wide so the clamp sees the true magnitude.
    logic signed [P2W-1:0] w_s_ext;
    logic signed [P2W-1:0] w_m_prod;
    logic signed [MW-1:0]  w_m;

    assign w_s_ext  = P2W'(r_s1_s);
    assign w_m_prod = w_s_ext * KV_C + HALF2;
    assign w_m      = MW'(w_m_prod >>> FRAC);

    // Stage 3: deadband first, then symmetric clamp; exactly +/-LIMIT passes unflagged.
    logic                w_in_db;
    logic signed [W-1:0] w_res;
    logic                w_sat;

    assign w_in_db = (r_s2_m < EPS_M) && (r_s2_m > -EPS_M);

    always_comb begin
        w_res = r_s2_m[W-1:0];
        w_sat = 1'b0;
        if (w_in_db) begin
            w_res = '0;
        end else if (r_s2_m > LIM_M) begin
            w_res = LIM_W;
            w_sat = 1'b1;
        end else if (r_s2_m < -LIM_M) begin
            w_res = -LIM_W;
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_s      <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_m      <= '0;
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_out_sat   <= 1'b0;
            r_sat_cnt   <= '0;
        end else begin
            if (w_adv) begin
                r_s1_valid  <= in_valid;
                r_s1_s      <= w_s;
                r_s2_valid  <= r_s1_valid;
                r_s2_m      <= w_m;
                r_out_valid <= r_s2_valid;
                r_out_y     <= w_res;
                r_out_sat   <= w_sat && r_s2_valid;
            end
            // Clear has priority over a same-cycle saturated transfer.
            if (clr_cnt) begin
                r_sat_cnt <= '0;
            end else if (r_out_valid && out_ready && r_out_sat && (r_sat_cnt != CNT_MAX)) begin
                r_sat_cnt <= r_sat_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = rst_n && !w_stall;
    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;
    assign out_sat   = r_out_sat;
    assign sat_cnt   = r_sat_cnt;

endmodule
